vend_ctrl: RTL and testbench

Parametrised vending controller for N coin buttons with configurable coin values and item price. Accepts coins and accumulates credit. Requests dispense from the mechanism through a req/ack handshake, with a timeout. Refunds remaining credit as paced change pulses. It is the next generation of the fixed two-coin, 50/100-to-200 credit FSM, adding cancel, change return, overflow rejection and fault handling.

---
 rtl/vend_pkg.sv | 25 ++
 rtl/vend_ctrl_oneshot.sv | 24 ++
 rtl/vend_ctrl.sv | 160 ++++++++++++++++
 tb/tb_vend_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: state encoding, default coin values and coin-value extraction for vend_ctrl
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam int COIN_50  = 50;
    localparam int COIN_100 = 100;
    localparam int COIN_500 = 500;

    // Widest packed coin-value vector the helper accepts
    localparam int VALS_MAX = 1024;

    // Slice coin value i (w bits wide) out of a packed vector, index 0 at the LSB
    function automatic logic [31:0] coin_val(input logic [VALS_MAX-1:0] vals, input int w, input int i);
        logic [VALS_MAX-1:0] s;
        s = vals >> (i * w);
        return s[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/vend_ctrl_oneshot.sv
// btn_oneshot: synchronise a raw button and emit one registered pulse per rising edge
module btn_oneshot
    import vend_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic trig
);

    logic [2:0] sync;

    // Two synchroniser stages plus a history stage; trig fires once when the level rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            trig <= 1'b0;
        end else begin
            sync <= {sync[1:0], btn};
            trig <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-accumulating vending controller with dispense handshake, timeout and paced change
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int NUM_COIN = 3,
    parameter int CREDIT_W = 10,
    parameter logic [NUM_COIN*CREDIT_W-1:0] COIN_VALS =
        {CREDIT_W'(COIN_500), CREDIT_W'(COIN_100), CREDIT_W'(COIN_50)},
    parameter int PRICE       = 200,
    parameter int MAX_CREDIT  = 600,
    parameter int CHANGE_UNIT = 50,
    parameter int CHANGE_GAP  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COIN-1:0] coin_btn,
    input  logic                cancel_btn,
    input  logic                vend_ack,
    output logic                vend_req,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                fault,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          state
);

    localparam int TW = $clog2(ACK_TIMEOUT + CHANGE_GAP + 1);
    localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C   = CREDIT_W'(CHANGE_UNIT);
    localparam logic [TW-1:0]       TO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0]       GAP_LAST = TW'(CHANGE_GAP - 1);

    if (MAX_CREDIT >= (1 << CREDIT_W) || PRICE > MAX_CREDIT || CHANGE_GAP < 2) begin : g_bad_params
        $error("vend_ctrl: MAX_CREDIT must fit CREDIT_W, PRICE <= MAX_CREDIT, CHANGE_GAP >= 2");
    end

    logic [NUM_COIN:0]   trig;
    logic [NUM_COIN-1:0] coin_trig;
    logic                cancel_trig;
    logic [CREDIT_W-1:0] val [NUM_COIN];

    assign coin_trig   = trig[NUM_COIN-1:0];
    assign cancel_trig = trig[NUM_COIN];

    for (genvar i = 0; i <= NUM_COIN; i++) begin : g_os
        btn_oneshot u_os (
            .clk  (clk),
            .rst  (rst),
            .btn  (i == NUM_COIN ? cancel_btn : coin_btn[i % NUM_COIN]),
            .trig (trig[i])
        );
    end

    for (genvar i = 0; i < NUM_COIN; i++) begin : g_val
        assign val[i] = CREDIT_W'(coin_val(VALS_MAX'(COIN_VALS), CREDIT_W, i));
    end

    state_t              state_q, state_n;
    logic [CREDIT_W-1:0] credit_q, credit_n, sel_val;
    logic [CREDIT_W:0]   sum;
    logic [TW-1:0]       timer_q, timer_n;
    logic                req_n, pulse_n, reject_n, fault_n, any_coin, multi;

    assign any_coin = |coin_trig;
    assign multi    = (coin_trig & (coin_trig - NUM_COIN'(1))) != '0;
    assign credit   = credit_q;
    assign state    = state_q;

    // Lowest-index coin wins when several triggers coincide
    always_comb begin
        sel_val = '0;
        for (int k = NUM_COIN - 1; k >= 0; k--)
            if (coin_trig[k]) sel_val = val[k];
    end

    // Next state, credit, shared timer and registered-output values
    always_comb begin
        state_n  = state_q;
        credit_n = credit_q;
        timer_n  = timer_q;
        req_n    = 1'b0;
        pulse_n  = 1'b0;
        reject_n = multi;
        fault_n  = 1'b0;
        sum      = {1'b0, credit_q} + {1'b0, sel_val};
        case (state_q)
            IDLE, COLLECT: begin
                if (state_q == COLLECT && credit_q >= PRICE_C) begin
                    // Committed to a vend: a coin landing in this cycle is already refused
                    state_n  = DISPENSE;
                    timer_n  = '0;
                    req_n    = 1'b1;
                    reject_n = any_coin;
                end else if (any_coin) begin
                    if (sum <= MAX_C) begin
                        credit_n = sum[CREDIT_W-1:0];
                        state_n  = COLLECT;
                    end else begin
                        reject_n = 1'b1;
                    end
                end else if (state_q == COLLECT && cancel_trig) begin
                    state_n = CHANGE;
                    timer_n = '0;
                end
            end
            DISPENSE: begin
                reject_n = any_coin;
                if (vend_ack) begin
                    credit_n = credit_q - PRICE_C;
                    state_n  = (credit_q == PRICE_C) ? IDLE : CHANGE;
                    timer_n  = '0;
                end else if (timer_q == TO_LAST) begin
                    fault_n = 1'b1;
                    state_n = CHANGE;
                    timer_n = '0;
                end else begin
                    req_n   = 1'b1;
                    timer_n = timer_q + TW'(1);
                end
            end
            default: begin
                reject_n = any_coin;
                if (credit_q == '0) begin
                    state_n = IDLE;
                end else if (timer_q == '0) begin
                    pulse_n  = 1'b1;
                    credit_n = credit_q - UNIT_C;
                    timer_n  = GAP_LAST;
                    state_n  = (credit_q == UNIT_C) ? IDLE : CHANGE;
                end else begin
                    timer_n = timer_q - TW'(1);
                end
            end
        endcase
    end

    // State, credit, timer and all outputs registered; async active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            timer_q      <= '0;
            vend_req     <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_n;
            credit_q     <= credit_n;
            timer_q      <= timer_n;
            vend_req     <= req_n;
            change_pulse <= pulse_n;
            coin_reject  <= reject_n;
            fault        <= fault_n;
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: table, directed and randomised checks of vend_ctrl against a behavioural model
module tb_vend_ctrl;

    localparam int NC = 3, CW = 10, PRICE = 200, MAXC = 600, UNIT = 50, GAP = 4, TMO = 16;
    localparam int S_IDLE = 0, S_COL = 1, S_DISP = 2, S_CHG = 3;

    logic          clk = 1'b0, rst = 1'b1;
    logic [NC-1:0] coin_btn = '0;
    logic          cancel_btn = 1'b0, vend_ack = 1'b0;
    logic          vend_req, change_pulse, coin_reject, fault;
    logic [CW-1:0] credit;
    logic [1:0]    state;

    int checks = 0, failures = 0, req_cnt = 0;

    vend_ctrl #(
        .NUM_COIN(NC), .CREDIT_W(CW), .COIN_VALS({10'd500, 10'd100, 10'd50}),
        .PRICE(PRICE), .MAX_CREDIT(MAXC), .CHANGE_UNIT(UNIT),
        .CHANGE_GAP(GAP), .ACK_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .coin_btn(coin_btn), .cancel_btn(cancel_btn),
        .vend_ack(vend_ack), .vend_req(vend_req), .change_pulse(change_pulse),
        .coin_reject(coin_reject), .fault(fault), .credit(credit), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural model: button history, machine phase, credit, wait and countdown counters
    int   hist [NC+1][5];
    int   m_mode, m_credit, m_waited, m_countdown;
    logic e_req, e_pulse, e_rej, e_fault;

    function automatic int coin_value(input int i);
        return i == 0 ? 50 : (i == 1 ? 100 : 500);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b <= NC; b++)
            for (int d = 0; d < 5; d++) hist[b][d] = 0;
        m_mode = S_IDLE; m_credit = 0; m_waited = 0; m_countdown = 0;
        e_req = 0; e_pulse = 0; e_rej = 0; e_fault = 0;
    endtask

    // A press is seen by the controller on the fourth edge after the level first rises
    task automatic model_edge();
        logic [NC:0] lv, t;
        int n, k;
        lv = {cancel_btn, coin_btn};
        for (int b = 0; b <= NC; b++) begin
            for (int d = 4; d > 0; d--) hist[b][d] = hist[b][d-1];
            hist[b][0] = lv[b] ? 1 : 0;
            t[b] = hist[b][3] == 1 && hist[b][4] == 0;
        end
        n = 0; k = -1;
        for (int c = 0; c < NC; c++)
            if (t[c]) begin
                n++;
                if (k < 0) k = c;
            end
        e_pulse = 0; e_fault = 0; e_rej = 0;
        if (m_mode == S_DISP || m_mode == S_CHG || (m_mode == S_COL && m_credit >= PRICE)) begin
            e_rej = n > 0;
            if (m_mode == S_COL) begin
                m_mode = S_DISP;
                m_waited = 0;
            end else if (m_mode == S_DISP) begin
                m_waited++;
                if (vend_ack) begin
                    m_credit -= PRICE;
                    m_mode = m_credit > 0 ? S_CHG : S_IDLE;
                    m_countdown = 1;
                end else if (m_waited == TMO) begin
                    e_fault = 1;
                    m_mode = S_CHG;
                    m_countdown = 1;
                end
            end else begin
                m_countdown--;
                if (m_countdown == 0) begin
                    e_pulse = 1;
                    m_credit -= UNIT;
                    m_countdown = GAP;
                    if (m_credit == 0) m_mode = S_IDLE;
                end
            end
        end else if (n > 0) begin
            e_rej = n > 1;
            if (m_credit + coin_value(k) <= MAXC) begin
                m_credit += coin_value(k);
                m_mode = S_COL;
            end else begin
                e_rej = 1;
            end
        end else if (m_mode == S_COL && t[NC]) begin
            m_mode = S_CHG;
            m_countdown = 1;
        end
        e_req = m_mode == S_DISP;
    endtask

    task automatic compare_model();
        check("state", 32'(state), m_mode);
        check("credit", 32'(credit), m_credit);
        check("vend_req", 32'(vend_req), 32'(e_req));
        check("change_pulse", 32'(change_pulse), 32'(e_pulse));
        check("coin_reject", 32'(coin_reject), 32'(e_rej));
        check("fault", 32'(fault), 32'(e_fault));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        if (vend_req) req_cnt++;
        compare_model();
    endtask

    task automatic press(input logic [NC:0] mask, input int hold);
        {cancel_btn, coin_btn} = mask;
        repeat (hold) step();
        {cancel_btn, coin_btn} = '0;
    endtask

    task automatic assert_reset(input string tag);
        rst = 1'b0;
        model_reset();
        #1;
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_credit"}, 32'(credit), 0);
        check({tag, "_outs"}, 32'({vend_req, change_pulse, coin_reject, fault}), 0);
        compare_model();
        repeat (2) step();
        rst = 1'b1;
    endtask

    // Run out a refund from just after entry into CHANGE, checking count and pacing
    task automatic drain(input string tag, input int exp_n);
        int np, first, last, bad;
        np = 0; first = -1; last = -1; bad = 0;
        for (int i = 1; i <= exp_n * GAP + 10 && state != 2'd0; i++) begin
            step();
            if (change_pulse) begin
                if (np == 0) first = i;
                else if (i - last != GAP) bad++;
                last = i;
                np++;
            end
        end
        check({tag, "_pulses"}, np, exp_n);
        check({tag, "_first"}, first, 1);
        check({tag, "_gap_err"}, bad, 0);
        check({tag, "_idle"}, 32'(state), S_IDLE);
        check({tag, "_credit0"}, 32'(credit), 0);
    endtask

    typedef struct {
        logic [NC:0] btns;
        int          credit;
        logic        rej;
        int          st;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int ft, req_before;
        logic [NC:0] m;

        tbl[0] = '{4'b0010, 100, 1'b0, S_COL};
        tbl[1] = '{4'b0001, 150, 1'b0, S_COL};
        tbl[2] = '{4'b0100, 150, 1'b1, S_COL};
        tbl[3] = '{4'b0011, 200, 1'b1, S_COL};
        tbl[4] = '{4'b0100, 200, 1'b1, S_DISP};
        tbl[5] = '{4'b1000, 200, 1'b0, S_DISP};

        model_reset();
        #1;
        assert_reset("reset");

        for (int v = 0; v < 6; v++) begin
            press(tbl[v].btns, 2);
            step();
            step();
            check($sformatf("tbl%0d_credit", v), 32'(credit), tbl[v].credit);
            check($sformatf("tbl%0d_reject", v), 32'(coin_reject), 32'(tbl[v].rej));
            check($sformatf("tbl%0d_state", v), 32'(state), tbl[v].st);
            step();
        end

        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        check("A_credit", 32'(credit), 0);
        check("A_state", 32'(state), S_IDLE);
        check("A_req", 32'(vend_req), 0);
        ft = 0;
        repeat (6) begin
            step();
            if (change_pulse) ft++;
        end
        check("A_no_change", ft, 0);

        press(4'b0100, 2);
        step();
        step();
        check("B_credit500", 32'(credit), 500);
        step();
        check("B_state_disp", 32'(state), S_DISP);
        check("B_req", 32'(vend_req), 1);
        step();
        step();
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        check("B_credit300", 32'(credit), 300);
        check("B_state_chg", 32'(state), S_CHG);
        drain("B", 6);

        req_before = req_cnt;
        press(4'b0001, 10);
        step();
        step();
        check("C_hold_credit", 32'(credit), 50);
        press(4'b1000, 2);
        step();
        step();
        check("C_state_chg", 32'(state), S_CHG);
        drain("C", 1);
        check("C_req_never", req_cnt - req_before, 0);

        press(4'b0010, 2);
        step();
        step();
        press(4'b0010, 2);
        step();
        step();
        check("D_credit200", 32'(credit), 200);
        step();
        check("D_state_disp", 32'(state), S_DISP);
        ft = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (fault) begin
                ft = i;
                break;
            end
        end
        check("D_fault_delay", ft, TMO);
        check("D_req_drop", 32'(vend_req), 0);
        check("D_credit_kept", 32'(credit), 200);
        drain("D", 4);

        press(4'b0010, 2);
        step();
        step();
        press(4'b0100, 2);
        step();
        step();
        check("E_credit_max", 32'(credit), 600);
        check("E_max_no_reject", 32'(coin_reject), 0);
        step();
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        check("E_credit400", 32'(credit), 400);
        step();
        check("E_first_pulse", 32'(change_pulse), 1);
        #3;
        assert_reset("E_rst");

        for (int i = 0; i < 4000; i++) begin
            m = {cancel_btn, coin_btn};
            for (int b = 0; b <= NC; b++)
                if ($urandom_range(0, 11) == 0) m[b] = ~m[b];
            {cancel_btn, coin_btn} = m;
            vend_ack = $urandom_range(0, 7) == 0;
            if (!rst && $urandom_range(0, 2) == 0) begin
                rst = 1'b1;
            end else if (rst && $urandom_range(0, 799) == 0) begin
                rst = 1'b0;
                model_reset();
                #1;
                compare_model();
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
